piso_stream: RTL and testbench

PISO_STREAM -- requirements
Module: piso_stream

---
 rtl/piso_stream.sv | 130 +++++++++++++
 tb/tb_piso_stream.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/piso_stream.sv
// Parallel-in serial-out shifter: captures a WIDTH-bit word and emits it one bit per accepted cycle.
// Latency: first bit valid the cycle after the load edge; done pulses the cycle after the final bit is accepted.
// Backpressure: shift_en=0 stalls the current bit; load_ready is high only in IDLE (one idle cycle between words).
//
// Parameters: WIDTH (2..64) word width; MSB_FIRST (1: bit WIDTH-1 first, 0: bit 0 first).
// Ports: clk, clr (sync active-high reset), load_valid/load_ready/d (parallel load handshake),
//        shift_en (consumer accepts current bit), v/v_valid (serial bit out), busy, done.
// Optional feature: define PISO_STREAM_PARITY_EN to append an even-parity bit after each word.
module piso_stream #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] d,
    input  logic             shift_en,
    output logic             v,
    output logic             v_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_STREAM_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             done_nxt;
    logic             bit_out;
`ifdef PISO_STREAM_PARITY_EN
    logic             par;
`endif

    // Output end of the shift register depends on bit order.
    assign bit_out = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];

    always_comb begin
        state_nxt  = state;
        done_nxt   = 1'b0;
        load_ready = 1'b0;
        v_valid    = 1'b0;
        busy       = 1'b0;
        v          = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                v_valid = 1'b1;
                busy    = 1'b1;
                v       = bit_out;
                if (shift_en && (cnt == LAST_IDX)) begin
`ifdef PISO_STREAM_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
`endif
                end
            end
`ifdef PISO_STREAM_PARITY_EN
            PARITY: begin
                v_valid = 1'b1;
                busy    = 1'b1;
                v       = par;
                if (shift_en) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
`ifdef PISO_STREAM_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        sreg <= d;
                        cnt  <= '0;
`ifdef PISO_STREAM_PARITY_EN
                        par  <= ^d;
`endif
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        // Move toward the output end, zero-filling behind.
                        if (MSB_FIRST != 0) begin
                            sreg <= {sreg[WIDTH-2:0], 1'b0};
                        end else begin
                            sreg <= {1'b0, sreg[WIDTH-1:1]};
                        end
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
module tb_piso_stream;

    localparam int W = 8;
`ifdef PISO_STREAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         load_valid = 1'b0;
    logic         shift_en = 1'b0;
    logic [W-1:0] d = '0;

    logic load_ready_a, v_a, v_valid_a, busy_a, done_a;
    logic load_ready_b, v_b, v_valid_b, busy_b, done_b;

    always #5 clk = ~clk;

    piso_stream #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .clr(clr), .load_valid(load_valid), .load_ready(load_ready_a),
        .d(d), .shift_en(shift_en), .v(v_a), .v_valid(v_valid_a), .busy(busy_a), .done(done_a)
    );

    piso_stream #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .clr(clr), .load_valid(load_valid), .load_ready(load_ready_b),
        .d(d), .shift_en(shift_en), .v(v_b), .v_valid(v_valid_b), .busy(busy_b), .done(done_b)
    );

    // Expected serial stream: one entry per bit still owed (both bit orders), last marks word end.
    typedef struct {
        bit a;
        bit b;
        bit last;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;
    bit   done_exp = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.a    = w[W-1-i];
            e.b    = w[i];
            e.last = (i == W - 1) && !PAR;
            q.push_back(e);
        end
        if (PAR) begin
            e.a    = ^w;
            e.b    = ^w;
            e.last = 1'b1;
            q.push_back(e);
        end
    endtask

    // One cycle of stimulus; the model learns the outcome of the edge afterwards.
    task automatic step(input bit c, input bit lv, input bit se, input logic [W-1:0] dd);
        bit ready_snap;
        clr        = c;
        load_valid = lv;
        shift_en   = se;
        d          = dd;
        ready_snap = (q.size() == 0);
        @(posedge clk);
        #1;
        if (c) begin
            q.delete();
        end else if (lv && ready_snap) begin
            push_word(dd);
        end
    endtask

    // Monitor: compare observed outputs against the head of the expected stream.
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_vld;
            bit nxt_done;
            exp_vld  = (q.size() != 0);
            nxt_done = 1'b0;
            chk("v_valid_msb", v_valid_a, exp_vld);
            chk("v_valid_lsb", v_valid_b, exp_vld);
            chk("busy_msb", busy_a, exp_vld);
            chk("busy_lsb", busy_b, exp_vld);
            chk("load_ready_msb", load_ready_a, !exp_vld);
            chk("load_ready_lsb", load_ready_b, !exp_vld);
            chk("done_msb", done_a, done_exp);
            chk("done_lsb", done_b, done_exp);
            if (exp_vld) begin
                chk("v_msb", v_a, q[0].a);
                chk("v_lsb", v_b, q[0].b);
                if (shift_en && !clr) begin
                    nxt_done = q[0].last;
                    void'(q.pop_front());
                end
            end else begin
                chk("v_idle_msb", v_a, 1'b0);
                chk("v_idle_lsb", v_b, 1'b0);
            end
            done_exp = nxt_done;
        end
    end

    initial begin
        // Reset from power-up.
        step(1, 0, 0, '0);
        step(1, 1, 1, 8'hFF);
        mon_en = 1'b1;

        // Single word, continuous acceptance.
        step(0, 1, 1, 8'hB0);
        for (int i = 0; i < W + 3; i++) step(0, 0, 1, 8'h00);

        // Back-to-back: load_valid held high, d changing every cycle.
        for (int i = 0; i < 3 * (W + 2); i++) step(0, 1, 1, 8'(8'h3C + i * 17));
        for (int i = 0; i < W + 3; i++) step(0, 0, 1, 8'h00);

        // Stall for three cycles while the third bit is presented.
        step(0, 1, 1, 8'hA5);
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);
        for (int i = 0; i < W + 3; i++) step(0, 0, 1, 8'h00);

        // Load attempt during SHIFT is ignored, then clr mid-word discards it.
        step(0, 1, 1, 8'hB0);
        step(0, 1, 1, 8'h00);
        step(0, 1, 1, 8'h00);
        step(1, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00);

        // clr together with a load offered in IDLE: not accepted.
        step(1, 1, 1, 8'hFF);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00);

        // clr on the very edge that would accept the last bit.
        step(0, 1, 1, 8'h81);
        for (int i = 0; i < W - 1 + (PAR ? 1 : 0); i++) step(0, 0, 1, 8'h00);
        step(1, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) != 0), 8'($urandom));
        end

        // Drain whatever is still in flight.
        for (int i = 0; i < W + 4; i++) step(0, 0, 1, 8'h00);
        chk("drain_empty", (q.size() == 0), 1'b1);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
